// File: rtl/tc_abs_pkg.sv
// Shared definitions for the tc_abs_16 unit and its round-robin scheduler.
package tc_abs_pkg;

    localparam int          ABS_W   = 16;
    localparam logic [15:0] ABS_MIN = 16'h8000;
    localparam logic [15:0] ABS_SAT = 16'h7FFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/tc_abs_16.sv
// Combinational two's-complement absolute value; 16'h8000 wraps to itself.
module tc_abs_16
    import tc_abs_pkg::*;
(
    input  logic [ABS_W-1:0] a,
    output logic [ABS_W-1:0] y
);

    // Negate when the sign bit is set.
    always_comb begin
        y = a[ABS_W-1] ? (~a + 1'b1) : a;
    end

endmodule

// File: rtl/tc_abs_sched_16_rr_arbiter.sv
// Round-robin priority search starting at ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // First set request at or after ptr wins; grant is one-hot or zero.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = ID_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_abs_sched_16.sv
// Round-robin scheduler sharing one tc_abs_16 among NUM_REQ valid/ready
// requesters, with a single-entry tagged result slot.
// Optional: define TC_ABS_SCHED_SAT_EN to saturate abs(16'h8000) to 16'h7FFF
// and flag it on rsp_ovf; otherwise it wraps and rsp_ovf is tied low.
//
// state | meaning
// ------+------------------------------------------
// EMPTY | result slot empty, rsp_valid=0
// FULL  | result slot holds a result, rsp_valid=1
module tc_abs_sched_16
    import tc_abs_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ABS_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ABS_W-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_ovf
);

    sched_state_t       state, state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               gany;
    logic               can_accept;
    logic               accept;
    logic [ABS_W-1:0]   sel_op;
    logic [ABS_W-1:0]   abs_y;
    logic [ABS_W-1:0]   res_data;
    logic               res_ovf;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign sel_op = req_data[gidx*ABS_W +: ABS_W];

    tc_abs_16 u_abs (
        .a (sel_op),
        .y (abs_y)
    );

    // Result formatting: saturate or wrap the single unrepresentable case.
    always_comb begin
`ifdef TC_ABS_SCHED_SAT_EN
        res_ovf  = (sel_op == ABS_MIN);
        res_data = res_ovf ? ABS_SAT : abs_y;
`else
        res_ovf  = 1'b0;
        res_data = abs_y;
`endif
    end

    // Next state and handshake; the slot frees up when the consumer takes it.
    always_comb begin
        state_nxt  = state;
        can_accept = (state == EMPTY) || rsp_ready;
        req_ready  = grant & {NUM_REQ{can_accept}};
        accept     = gany && can_accept;
        if (accept)
            state_nxt = FULL;
        else if (rsp_ready)
            state_nxt = EMPTY;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Result slot and round-robin pointer; both only move on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_ovf  <= 1'b0;
            rr_ptr   <= '0;
        end else if (accept) begin
            rsp_data <= res_data;
            rsp_id   <= gidx;
            rsp_ovf  <= res_ovf;
            rr_ptr   <= ID_W'((int'(gidx) + 1) % NUM_REQ);
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_tc_abs_sched_16.sv
// Bench for tc_abs_sched_16: directed steps then random traffic, all checked
// against a transaction-level model of the scheduler.
module tb_tc_abs_sched_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;

    int compared   = 0;
    int mismatched = 0;

    // Model state: next lane to search from and the result slot.
    int ptr  = 0;
    bit mv   = 0;
    int md   = 0;
    int mid  = 0;
    bit movf = 0;

    tc_abs_sched_16 #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Magnitude of a signed 16-bit value; 32768 has no positive encoding.
    function automatic void ref_abs(input logic [15:0] x, output int mag, output bit ovf);
        int v;
        v   = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
        mag = (v < 0) ? -v : v;
        ovf = 0;
        if (mag == 32768) begin
`ifdef TC_ABS_SCHED_SAT_EN
            mag = 32767;
            ovf = 1;
`else
            mag = 32768;
`endif
        end
    endfunction

    // One clock of traffic: drive, check ready, advance model, check slot.
    task automatic step(input logic [3:0] v, input logic [63:0] d, input bit rr, input bit rst);
        int  g;
        int  mag;
        bit  ovf;
        bit  can;
        logic [3:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        rst_n     = !rst;
        #1;
        can = !mv || rr;
        g   = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && v[(ptr + k) % 4]) g = (ptr + k) % 4;
        end
        exp_rdy = (g >= 0 && can) ? 4'(1 << g) : 4'b0;
        if (!rst) check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            mv = 0; md = 0; mid = 0; movf = 0; ptr = 0;
        end else if (g >= 0 && can) begin
            ref_abs(d[g*16 +: 16], mag, ovf);
            mv = 1; md = mag; mid = g; movf = ovf; ptr = (g + 1) % 4;
        end else if (rr) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(mv));
        check("rsp_data",  32'(rsp_data),  32'(md));
        check("rsp_id",    32'(rsp_id),    32'(mid));
        check("rsp_ovf",   32'(rsp_ovf),   32'(movf));
    endtask

    function automatic logic [63:0] lanes(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        logic [63:0] d;
        logic [3:0]  v;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        step(4'b0000, 64'd0, 1'b0, 1'b1);
        step(4'b0000, 64'd0, 1'b0, 1'b1);

        // Basic single request on lane 0, then drain.
        step(4'b0001, lanes(16'd1, 16'd0, 16'd0, 16'd0), 1'b0, 1'b0);
        step(4'b0000, 64'd0, 1'b1, 1'b0);

        // Negative operand on lane 2.
        step(4'b0100, lanes(16'd0, 16'd0, -16'sd234, 16'd0), 1'b1, 1'b0);
        step(4'b0000, 64'd0, 1'b1, 1'b0);

        // Reset pointer, then full round robin with rsp_ready held.
        step(4'b0000, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(4'b1111, lanes(16'd1, -16'sd2, 16'd3, -16'sd4), 1'b1, 1'b0);

        // Backpressure with lane 1 pending.
        for (int i = 0; i < 3; i++)
            step(4'b0010, lanes(16'd7, 16'hFF00, 16'd0, 16'd0), 1'b0, 1'b0);
        step(4'b0010, lanes(16'd7, 16'hFF00, 16'd0, 16'd0), 1'b1, 1'b0);
        step(4'b0000, 64'd0, 1'b1, 1'b0);

        // Most negative operand on lane 3.
        step(4'b1000, lanes(16'd0, 16'd0, 16'd0, 16'h8000), 1'b1, 1'b0);
        step(4'b0000, 64'd0, 1'b1, 1'b0);

        // Reset while full with pending valids, then lane 0 wins first.
        step(4'b0110, lanes(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b0);
        step(4'b0110, lanes(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 1'b1);
        step(4'b1111, lanes(16'd5, 16'd6, 16'd7, 16'd8), 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            v = 4'($urandom_range(0, 15));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0)
                d[$urandom_range(0, 3)*16 +: 16] = 16'h8000;
            step(v, d, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tc_abs_sched_16.md
Name: tc_abs_sched_16

Overview:
- Round-robin scheduler that shares one combinational tc_abs_16 unit among NUM_REQ requesters.
- Each requester uses a valid/ready interface. The result is registered in a single-entry output slot and tagged with the requester index.
- Sits between multiple datapath lanes and one abs resource, so the design needs only one instance of that unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived localparam, not overridable).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_data  input  NUM_REQ*16  packed operands; requester i occupies bits [16*i+15:16*i], two's complement.
- req_ready  output  NUM_REQ  one-hot-or-zero grant/accept.
- rsp_valid  output  1  result slot full.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  16  |operand|.
- rsp_id  output  ID_W  index of the requester that produced rsp_data.
- rsp_ovf  output  1  operand was 16'h8000 (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, rr_ptr=0, FSM=EMPTY. Reset wins over any handshake in the same cycle; an in-flight result is discarded.
- FSM states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = (state==EMPTY) || rsp_ready.
- Arbitration is combinational each cycle:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit g is the winner.
  - req_ready[g]=can_accept; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready is all 0.
  - req_ready does not depend on req_valid of the granted lane beyond arbitration (no combinational loop with rsp_ready other than via can_accept).
- Accept (req_valid[g] && req_ready[g]) at edge k:
  - rsp_data <= abs(req_data lane g), rsp_id <= g, rsp_valid <= 1 after edge k. Latency is one cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL with rsp_ready and no accept: FULL to EMPTY.
  - FULL with rsp_ready and an accept: stays FULL and loads the new result (full throughput, one op per cycle).
  - FULL with no rsp_ready: hold; rsp_data, rsp_id and rsp_ovf stay stable; req_ready is all 0.
- rr_ptr changes only on accept, so a requester that is not granted keeps its position. Worst-case wait is NUM_REQ-1 accepts (no starvation).
- Arithmetic: abs(x) = x[15] ? (~x+1) : x, 16-bit result. abs(16'h8000) is handled per the Optional Feature.
- Requesters may drop req_valid without being granted; the scheduler keeps no per-lane state.

Optional Feature:
- Macro: TC_ABS_SCHED_SAT_EN.
- Defined: operand 16'h8000 yields rsp_data=16'h7FFF and rsp_ovf=1. All other operands give rsp_ovf=0.
- Undefined: operand 16'h8000 yields rsp_data=16'h8000 (wrap, identical to tc_abs_16), and rsp_ovf is tied to 0.

Decomposition:
- Shared package tc_abs_pkg holds:
  - ABS_W=16;
  - ABS_MIN=16'h8000;
  - ABS_SAT=16'h7FFF;
  - the FSM state typedef sched_state_t {EMPTY, FULL}.
- Sub-module rr_arbiter: combinational priority search from rr_ptr, output one-hot grant and binary index.
- The top level owns rr_ptr, the FSM, the output register and the tc_abs_16 instance.

Test Plan:
- Basic: reset, then req_valid=4'b0001, lane0=16'd1 -> req_ready=4'b0001; next cycle rsp_valid=1, rsp_data=16'd1, rsp_id=0.
- Negative operand: lane2=-16'd234 alone -> rsp_data=16'd234, rsp_id=2, rsp_ovf=0.
- Round robin: all four lanes valid, rsp_ready=1 held, lane values 1, -2, 3, -4 -> grants in order 0,1,2,3,0 on consecutive cycles; rsp_data sequence 1,2,3,4, with a result every cycle.
- Backpressure: rsp_ready=0 for 3 cycles while FULL with lane1 valid -> req_ready=0, rsp_data/rsp_id stable. On the cycle rsp_ready=1, lane1 is granted and its result appears the next cycle.
- Boundary: lane3=16'h8000 -> rsp_data=16'h7FFF, rsp_ovf=1 with TC_ABS_SCHED_SAT_EN; rsp_data=16'h8000, rsp_ovf=0 without it.
- Reset mid-operation: assert rst_n=0 while FULL with pending valids -> after that edge rsp_valid=0 and rr_ptr=0. After release, lane0 wins first.
